// File: rtl/fcmp_vec.sv
// Vector floating-point compare / min / max, NUM_LANES lanes, two-stage pipeline
// with valid/ready flow control. Stage 1 classifies operands, stage 2 selects results.
module fcmp_vec #(
    parameter int EXPWIDTH  = 8,
    parameter int PRECISION = 24,
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    input  logic [2:0]                                    op_i,
    input  logic [NUM_LANES*(EXPWIDTH+PRECISION)-1:0]     a_i,
    input  logic [NUM_LANES*(EXPWIDTH+PRECISION)-1:0]     b_i,
    input  logic [NUM_LANES-1:0]                          mask_i,
    input  logic [TAG_WIDTH-1:0]                          tag_i,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic [NUM_LANES*(EXPWIDTH+PRECISION)-1:0]     result_o,
    output logic [4:0]                                    fflags_o,
    output logic [NUM_LANES-1:0]                          mask_o,
    output logic [TAG_WIDTH-1:0]                          tag_o
);

    localparam int W  = EXPWIDTH + PRECISION;
    localparam int FW = PRECISION - 1;
    localparam int VW = NUM_LANES * W;

    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FNE  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FLT  = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;
    localparam logic [2:0] OP_FMIN = 3'd5;

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(PRECISION-2){1'b0}}};

    logic                 v1, v2;
    logic                 adv2;

    logic [NUM_LANES-1:0] eq_c, lt_c, le_c, tlt_c, anan_c, bnan_c, asnan_c, bsnan_c;

    logic [NUM_LANES-1:0] s1_eq, s1_lt, s1_le, s1_tlt;
    logic [NUM_LANES-1:0] s1_anan, s1_bnan, s1_asnan, s1_bsnan;
    logic [VW-1:0]        s1_a, s1_b;
    logic [2:0]           s1_op;
    logic [NUM_LANES-1:0] s1_mask;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic [VW-1:0]        res_c;
    logic                 nv_c;

    assign in_ready_o  = !(v1 && v2 && !out_ready_i);
    assign adv2        = v1 && !(v2 && !out_ready_i);
    assign out_valid_o = v2;

    // tlt is a total order on non-NaN values where -0 < +0; lt/eq treat the zeros as equal.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [W-1:0]        a, b;
        logic [W-2:0]        a_mag, b_mag;
        logic [EXPWIDTH-1:0] a_exp, b_exp;
        logic [FW-1:0]       a_frac, b_frac;
        logic                both_zero, any_nan, tlt;

        assign a      = a_i[k*W +: W];
        assign b      = b_i[k*W +: W];
        assign a_mag  = a[W-2:0];
        assign b_mag  = b[W-2:0];
        assign a_exp  = a[W-2 -: EXPWIDTH];
        assign b_exp  = b[W-2 -: EXPWIDTH];
        assign a_frac = a[FW-1:0];
        assign b_frac = b[FW-1:0];

        assign anan_c[k]  = (&a_exp) && (|a_frac);
        assign bnan_c[k]  = (&b_exp) && (|b_frac);
        assign asnan_c[k] = anan_c[k] && !a_frac[FW-1];
        assign bsnan_c[k] = bnan_c[k] && !b_frac[FW-1];

        assign both_zero = (a_mag == '0) && (b_mag == '0);
        assign any_nan   = anan_c[k] || bnan_c[k];
        assign tlt       = (a[W-1] != b[W-1]) ? a[W-1] :
                           (a[W-1] ? (a_mag > b_mag) : (a_mag < b_mag));

        assign tlt_c[k] = tlt;
        assign eq_c[k]  = !any_nan && ((a == b) || both_zero);
        assign lt_c[k]  = !any_nan && tlt && !both_zero;
        assign le_c[k]  = lt_c[k] || eq_c[k];
    end

    always_comb begin
        res_c = '0;
        nv_c  = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (s1_mask[k]) begin
                case (s1_op)
                    OP_FEQ: begin
                        res_c[k*W +: W] = W'(s1_eq[k]);
                        nv_c = nv_c | s1_asnan[k] | s1_bsnan[k];
                    end
                    OP_FNE: begin
                        res_c[k*W +: W] = W'(!s1_eq[k]);
                        nv_c = nv_c | s1_asnan[k] | s1_bsnan[k];
                    end
                    OP_FLE: begin
                        res_c[k*W +: W] = W'(s1_le[k]);
                        nv_c = nv_c | s1_anan[k] | s1_bnan[k];
                    end
                    OP_FLT: begin
                        res_c[k*W +: W] = W'(s1_lt[k]);
                        nv_c = nv_c | s1_anan[k] | s1_bnan[k];
                    end
                    OP_FMAX, OP_FMIN: begin
                        if (s1_anan[k] && s1_bnan[k])
                            res_c[k*W +: W] = CANON_NAN;
                        else if (s1_anan[k])
                            res_c[k*W +: W] = s1_b[k*W +: W];
                        else if (s1_bnan[k])
                            res_c[k*W +: W] = s1_a[k*W +: W];
                        else if (s1_tlt[k] ^ (s1_op == OP_FMIN))
                            res_c[k*W +: W] = s1_b[k*W +: W];
                        else
                            res_c[k*W +: W] = s1_a[k*W +: W];
                        nv_c = nv_c | s1_asnan[k] | s1_bsnan[k];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1_eq     <= '0;
            s1_lt     <= '0;
            s1_le     <= '0;
            s1_tlt    <= '0;
            s1_anan   <= '0;
            s1_bnan   <= '0;
            s1_asnan  <= '0;
            s1_bsnan  <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_mask   <= '0;
            s1_tag    <= '0;
            result_o  <= '0;
            fflags_o  <= '0;
            mask_o    <= '0;
            tag_o     <= '0;
        end else begin
            if (in_ready_o) begin
                v1 <= in_valid_i;
                if (in_valid_i) begin
                    s1_eq    <= eq_c;
                    s1_lt    <= lt_c;
                    s1_le    <= le_c;
                    s1_tlt   <= tlt_c;
                    s1_anan  <= anan_c;
                    s1_bnan  <= bnan_c;
                    s1_asnan <= asnan_c;
                    s1_bsnan <= bsnan_c;
                    s1_a     <= a_i;
                    s1_b     <= b_i;
                    s1_op    <= op_i;
                    s1_mask  <= mask_i;
                    s1_tag   <= tag_i;
                end
            end
            if (adv2) begin
                v2       <= 1'b1;
                result_o <= res_c;
                fflags_o <= {nv_c, 4'b0000};
                mask_o   <= s1_mask;
                tag_o    <= s1_tag;
            end else if (out_ready_i) begin
                v2 <= 1'b0;
            end
        end
    end

endmodule
